mips_data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the pipeline's data-memory port (data_adr, data_out, data_in, mem_read, mem_write) and a multi-cycle main memory.
- Read hits return data combinationally in the same cycle.
- Read misses fill a 4-word line from memory while holding the pipeline via stall.
- Writes go through to memory and also update the cached word on a hit. The pipeline freezes all stages while stall=1.

---
 rtl/mips_data_cache.sv | 195 +++++++++++++++++++
 tb/tb_mips_data_cache.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_cache.sv
// mips_data_cache
//   Direct-mapped, write-through, no-write-allocate data cache between the
//   pipeline MEM stage and a multi-cycle main memory. Lines are 4 x 32-bit.
//   Load hits return data in the same cycle. Load misses stall the pipeline
//   while the line is filled. Stores always go to memory and also update the
//   cached word when the line is present.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   cpu_adr            byte address from the MEM stage (bits[1:0] ignored)
//   cpu_wdata          store data
//   cpu_rd, cpu_wr     load / store request (store wins if both are set)
//   cpu_rdata          load data, valid when cpu_rd=1 and stall=0
//   stall              combinational pipeline hold
//   mem_adr, mem_wdata word-aligned memory address / write data
//   mem_rd_req         memory read request (line fill)
//   mem_wr_req         memory write request (store write-through)
//   mem_rdata          memory read data, valid with mem_ready
//   mem_ready          one-cycle completion of the current memory request
//   hit_count          completed load hits, saturating
//   miss_count         load misses, saturating
module mips_data_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_BITS = 32 - 4 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t state, state_nx;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_arr  [LINES];
  logic [31:0]         data_arr [LINES*4];

  // Fill context: line base address (cpu_adr[31:4]) and word counter.
  logic [27:0] fill_base;
  logic [1:0]  fill_cnt;
  // High for the one IDLE cycle right after a fill, when the stalled load is
  // re-presented; that hit is the completion of a miss, not a new hit.
  logic        fill_done;

  // Registered store address/data, driven straight onto the memory port.
  logic [31:0] wr_adr;
  logic [31:0] wr_data;

  logic [1:0]            cpu_off;
  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_BITS-1:0]   cpu_tag;
  logic                  cpu_hit;

  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;

  logic [1:0]            wr_off;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0]   wr_tag;
  logic                  wr_hit;

  logic load_hit, load_miss, fill_we, fill_last, wr_upd;
  logic unused_adr_bits;

  assign unused_adr_bits = ^cpu_adr[1:0];

  assign cpu_off = cpu_adr[3:2];
  assign cpu_idx = cpu_adr[4+INDEX_BITS-1:4];
  assign cpu_tag = cpu_adr[31:4+INDEX_BITS];
  assign cpu_hit = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

  assign fill_idx = fill_base[INDEX_BITS-1:0];
  assign fill_tag = fill_base[27:INDEX_BITS];

  assign wr_off = wr_adr[3:2];
  assign wr_idx = wr_adr[4+INDEX_BITS-1:4];
  assign wr_tag = wr_adr[31:4+INDEX_BITS];
  assign wr_hit = valid[wr_idx] && (tag_arr[wr_idx] == wr_tag);

  assign cpu_rdata = data_arr[{cpu_idx, cpu_off}];
  assign mem_adr   = (state == FILL) ? {fill_base, fill_cnt, 2'b00} : wr_adr;
  assign mem_wdata = wr_data;

  // Next-state and request/stall decode
  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    load_hit   = 1'b0;
    load_miss  = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    wr_upd     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          stall    = 1'b1;
          state_nx = WRITE;
        end else if (cpu_rd) begin
          if (cpu_hit) begin
            load_hit = 1'b1;
          end else begin
            stall     = 1'b1;
            load_miss = 1'b1;
            state_nx  = FILL;
          end
        end
      end
      FILL: begin
        stall      = 1'b1;
        mem_rd_req = 1'b1;
        if (mem_ready) begin
          fill_we = 1'b1;
          if (fill_cnt == 2'd3) begin
            fill_last = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      WRITE: begin
        mem_wr_req = 1'b1;
        // The store retires in the cycle memory accepts it.
        stall      = !mem_ready;
        if (mem_ready) begin
          wr_upd   = wr_hit;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state, counters and memory-port registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      valid      <= '0;
      fill_cnt   <= 2'd0;
      fill_done  <= 1'b0;
      wr_adr     <= 32'd0;
      wr_data    <= 32'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      state     <= state_nx;
      fill_done <= fill_last;
      if (load_hit && !fill_done) hit_count <= sat_inc(hit_count);
      if (load_miss) begin
        miss_count <= sat_inc(miss_count);
        fill_cnt   <= 2'd0;
      end
      if (fill_we) fill_cnt <= fill_cnt + 2'd1;
      // A line only becomes valid once all four words have landed.
      if (fill_last) valid[fill_idx] <= 1'b1;
      if (state == IDLE && cpu_wr) begin
        wr_adr  <= {cpu_adr[31:2], 2'b00};
        wr_data <= cpu_wdata;
      end
    end
  end

  // Tag/data storage and fill base; contents are qualified by valid
  always_ff @(posedge clk) begin
    if (load_miss) fill_base <= cpu_adr[31:4];
    if (fill_we)   data_arr[{fill_idx, fill_cnt}] <= mem_rdata;
    if (fill_last) tag_arr[fill_idx] <= fill_tag;
    if (wr_upd)    data_arr[{wr_idx, wr_off}] <= wr_data;
  end

endmodule

// File: tb/tb_mips_data_cache.sv
module tb_mips_data_cache;

  localparam int IB = 6;
  localparam int NL = 1 << IB;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic        cpu_rd, cpu_wr, stall;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic        mem_rd_req, mem_wr_req, mem_ready;
  logic [31:0] hit_count, miss_count;

  always #5 clk = ~clk;

  mips_data_cache #(.INDEX_BITS(IB)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Initial memory image: 0x40 holds 0x1111_0000, each following word +1.
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return 32'h1111_0000 + ((a - 32'h40) >> 2);
  endfunction

  // Environment memory (what the DUT's memory port actually sees).
  logic [31:0] env_mem [logic [31:0]];
  function automatic logic [31:0] env_read(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : mem_init(a);
  endfunction

  // Reference model: per line index, which line base address is resident and
  // its four words; plus the architectural memory contents and counters.
  bit          ref_valid [NL];
  logic [31:0] ref_line  [NL];
  logic [31:0] ref_data  [NL][4];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] ref_hit, ref_miss;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    ref_hit  = 32'd0;
    ref_miss = 32'd0;
  endtask

  // Memory responder: mem_lat wait cycles before mem_ready on each request.
  // Outside a request mem_ready toggles randomly; the cache must ignore it.
  int mem_lat = 0;
  int mem_cnt = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_rd_req || mem_wr_req) begin
        if (mem_ready) mem_cnt = 0;
        mem_ready = (mem_cnt >= mem_lat);
        mem_cnt++;
        mem_rdata = mem_rd_req ? env_read(mem_adr) : $urandom;
        if (mem_ready && mem_wr_req) env_mem[mem_adr] = mem_wdata;
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        mem_cnt   = 0;
      end
    end
  end

  task automatic do_load(input logic [31:0] a, input int lat);
    logic [31:0] base, got, exp_a;
    int stalls, fills, bad_fill, idx, tmo;
    bit exp_hit;
    base    = a & ~32'hF;
    idx     = int'((a >> 4) % NL);
    exp_hit = ref_valid[idx] && (ref_line[idx] == base);
    mem_lat = lat;
    cpu_adr = a; cpu_rd = 1'b1; cpu_wr = 1'b0;
    stalls = 0; fills = 0; bad_fill = 0;
    for (tmo = 0; tmo < 200; tmo++) begin
      @(negedge clk);
      if (mem_rd_req && mem_ready) begin
        exp_a = base + 32'(4 * fills);
        if (mem_adr !== exp_a) bad_fill++;
        fills++;
      end
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    got = cpu_rdata;
    chk("load_done", 32'(tmo < 200), 32'd1);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    if (exp_hit) begin
      ref_hit = ref_hit + 1;
    end else begin
      ref_miss       = ref_miss + 1;
      ref_valid[idx] = 1'b1;
      ref_line[idx]  = base;
      for (int k = 0; k < 4; k++) ref_data[idx][k] = ref_read(base + 32'(4 * k));
    end
    chk("load_data",  got, ref_data[idx][(a >> 2) & 3]);
    chk("load_stall", 32'(stalls), 32'(exp_hit ? 0 : 1 + 4 * (lat + 1)));
    chk("fill_beats", 32'(fills), 32'(exp_hit ? 0 : 4));
    chk("fill_adr",   32'(bad_fill), 32'd0);
    chk("hit_count",  hit_count, ref_hit);
    chk("miss_count", miss_count, ref_miss);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat,
                          input bit also_rd);
    logic [31:0] wa;
    int stalls, wr_cycles, bad, idx, tmo;
    wa      = a & ~32'h3;
    idx     = int'((a >> 4) % NL);
    mem_lat = lat;
    cpu_adr = a; cpu_wdata = d; cpu_wr = 1'b1; cpu_rd = also_rd;
    stalls = 0; wr_cycles = 0; bad = 0;
    for (tmo = 0; tmo < 200; tmo++) begin
      @(negedge clk);
      if (mem_rd_req) bad++;
      if (mem_wr_req) begin
        wr_cycles++;
        if (mem_adr !== wa || mem_wdata !== d) bad++;
      end
      if (!stall) break;
      stalls++;
      @(posedge clk); #1;
    end
    chk("store_done", 32'(tmo < 200), 32'd1);
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    ref_mem[wa] = d;
    if (ref_valid[idx] && ref_line[idx] == (a & ~32'hF)) ref_data[idx][(a >> 2) & 3] = d;
    chk("store_stall",  32'(stalls), 32'(1 + lat));
    chk("store_req",    32'(wr_cycles), 32'(lat + 1));
    chk("store_port",   32'(bad), 32'd0);
    chk("store_memory", env_read(wa), d);
    chk("miss_count",   miss_count, ref_miss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cpu_adr = 32'd0; cpu_wdata = 32'd0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_stall",  32'(stall), 32'd0);
    chk("rst_rd_req", 32'(mem_rd_req), 32'd0);
    chk("rst_wr_req", 32'(mem_wr_req), 32'd0);
    chk("rst_adr",    mem_adr, 32'd0);
    chk("rst_wdata",  mem_wdata, 32'd0);
    chk("rst_hits",   hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clk); #1;

    // Cold miss, then hits on the rest of the line
    do_load(32'h0000_0040, 0);
    do_load(32'h0000_0044, 0);
    do_load(32'h0000_0048, 0);
    do_load(32'h0000_004C, 0);
    // Store hit with a slow memory, then read it back
    do_store(32'h0000_0044, 32'hDEAD_BEEF, 2, 1'b0);
    do_load(32'h0000_0044, 0);
    // Store to an uncached line: write-through only
    do_store(32'h0000_1000, 32'hCAFE_0001, 1, 1'b0);
    do_load(32'h0000_1000, 1);
    // Conflict on the same index
    do_load(32'h0000_0040, 0);
    do_load(32'h0000_0040 + (32'd1 << (4 + IB)), 0);
    do_load(32'h0000_0040, 0);

    // Reset during the third fill word
    mem_lat = 0;
    cpu_adr = 32'h0000_2050; cpu_rd = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    chk("abort_stall",  32'(stall), 32'd0);
    chk("abort_rd_req", 32'(mem_rd_req), 32'd0);
    chk("abort_hits",   hit_count, 32'd0);
    chk("abort_misses", miss_count, 32'd0);
    @(posedge clk); #1;
    do_load(32'h0000_2050, 0);
    do_load(32'h0000_0040, 0);

    // Randomized traffic over a few conflicting lines
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int lat;
      a   = (32'($urandom_range(0, 3)) << (4 + IB)) | (32'($urandom_range(0, 3)) << 4)
          | 32'($urandom_range(0, 15));
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 7) do_load(a, lat);
      else do_store(a, $urandom, lat, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
